// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register carrying an opaque payload with a valid/ready handshake.
// It has an optional 2-entry skid buffer, a synchronous flush to NOP and a saturating stall counter.
module pipe_stage_hs #(
    parameter int              DW          = 171,
    parameter logic [DW-1:0]   NOP_PAYLOAD = '0,
    parameter bit              SKID        = 1'b1,
    parameter int              CW          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data,
    output logic [1:0]    occ,
    input  logic          clr_cnt,
    output logic [CW-1:0] stall_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW-1:0] main_reg;
    logic          up_xfer;
    logic          dn_xfer;

    assign up_xfer = up_valid & up_ready;
    assign dn_xfer = dn_valid & dn_ready;
    assign dn_data = main_reg;

    generate
        if (SKID) begin : g_skid
            typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

            state_t        state;
            logic [DW-1:0] skid_reg;
            logic          up_ready_reg;
            logic          dn_valid_reg;
            logic [1:0]    occ_reg;

            // NOTE: payload registers are reset and flushed to NOP so dn_data is NOP whenever the stage is empty.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state        <= EMPTY;
                    main_reg     <= NOP_PAYLOAD;
                    skid_reg     <= NOP_PAYLOAD;
                    up_ready_reg <= 1'b1;
                    dn_valid_reg <= 1'b0;
                    occ_reg      <= 2'd0;
                end else if (flush) begin
                    state        <= EMPTY;
                    main_reg     <= NOP_PAYLOAD;
                    skid_reg     <= NOP_PAYLOAD;
                    up_ready_reg <= 1'b1;
                    dn_valid_reg <= 1'b0;
                    occ_reg      <= 2'd0;
                end else begin
                    unique case (state)
                        EMPTY: begin
                            if (up_xfer) begin
                                state        <= ONE;
                                main_reg     <= up_data;
                                dn_valid_reg <= 1'b1;
                                occ_reg      <= 2'd1;
                            end
                        end
                        ONE: begin
                            if (up_xfer && dn_xfer) begin
                                main_reg <= up_data;
                            end else if (up_xfer) begin
                                state        <= TWO;
                                skid_reg     <= up_data;
                                up_ready_reg <= 1'b0;
                                occ_reg      <= 2'd2;
                            end else if (dn_xfer) begin
                                state        <= EMPTY;
                                main_reg     <= NOP_PAYLOAD;
                                dn_valid_reg <= 1'b0;
                                occ_reg      <= 2'd0;
                            end
                        end
                        TWO: begin
                            if (dn_xfer) begin
                                state        <= ONE;
                                main_reg     <= skid_reg;
                                skid_reg     <= NOP_PAYLOAD;
                                up_ready_reg <= 1'b1;
                                occ_reg      <= 2'd1;
                            end
                        end
                        default: begin
                            state <= EMPTY;
                        end
                    endcase
                end
            end

            assign up_ready = up_ready_reg;
            assign dn_valid = dn_valid_reg;
            assign occ      = occ_reg;
        end else begin : g_single
            logic dn_valid_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_reg     <= NOP_PAYLOAD;
                    dn_valid_reg <= 1'b0;
                end else if (flush) begin
                    main_reg     <= NOP_PAYLOAD;
                    dn_valid_reg <= 1'b0;
                end else if (up_xfer) begin
                    main_reg     <= up_data;
                    dn_valid_reg <= 1'b1;
                end else if (dn_xfer) begin
                    main_reg     <= NOP_PAYLOAD;
                    dn_valid_reg <= 1'b0;
                end
            end

            // NOTE: without a skid entry the stage can only refill in the same cycle it drains, so ready is combinational.
            assign up_ready = dn_ready | ~dn_valid_reg;
            assign dn_valid = dn_valid_reg;
            assign occ      = {1'b0, dn_valid_reg};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (dn_valid && !dn_ready && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: one skid instance and one single-register instance, each checked every cycle
// against a FIFO-occupancy model, plus directed scenarios with literal expectations.
module tb_pipe_stage_hs;

    localparam int            DW    = 171;
    localparam logic [DW-1:0] NOP_A = '0;
    localparam logic [DW-1:0] NOP_B = {DW{1'b1}};
    localparam int            MAX_A = 65535;
    localparam int            MAX_B = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          flush[2];
    logic          up_valid[2];
    logic          dn_ready[2];
    logic          clr_cnt[2];
    logic [DW-1:0] up_data[2];
    logic          up_ready[2];
    logic          dn_valid[2];
    logic [DW-1:0] dn_data[2];
    logic [1:0]    occ[2];
    logic [15:0]   stall_a;
    logic [3:0]    stall_b;

    pipe_stage_hs #(.DW(DW), .NOP_PAYLOAD(NOP_A), .SKID(1'b1), .CW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]),
        .up_valid(up_valid[0]), .up_ready(up_ready[0]), .up_data(up_data[0]),
        .dn_valid(dn_valid[0]), .dn_ready(dn_ready[0]), .dn_data(dn_data[0]),
        .occ(occ[0]), .clr_cnt(clr_cnt[0]), .stall_cnt(stall_a)
    );

    pipe_stage_hs #(.DW(DW), .NOP_PAYLOAD(NOP_B), .SKID(1'b0), .CW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]),
        .up_valid(up_valid[1]), .up_ready(up_ready[1]), .up_data(up_data[1]),
        .dn_valid(dn_valid[1]), .dn_ready(dn_ready[1]), .dn_data(dn_data[1]),
        .occ(occ[1]), .clr_cnt(clr_cnt[1]), .stall_cnt(stall_b)
    );

    int checks = 0;
    int errors = 0;

    // Model: each stage is an in-order FIFO of capacity 2 (channel 0) or 1 (channel 1).
    logic [DW-1:0] mq[2][2];
    int            mn[2];
    int            mstall[2];
    bit            stuck[2];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic exp_up_ready(input int c);
        if (c == 0) return logic'(mn[0] < 2);
        return logic'(dn_ready[1] || mn[1] == 0);
    endfunction

    function automatic logic [DW-1:0] exp_dn_data(input int c);
        if (mn[c] > 0) return mq[c][0];
        return (c == 0) ? NOP_A : NOP_B;
    endfunction

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            check($sformatf("up_ready%0d", c), DW'(up_ready[c]), DW'(exp_up_ready(c)));
            check($sformatf("dn_valid%0d", c), DW'(dn_valid[c]), DW'(mn[c] > 0));
            check($sformatf("dn_data%0d", c), dn_data[c], exp_dn_data(c));
            check($sformatf("occ%0d", c), DW'(occ[c]), DW'(mn[c]));
            check($sformatf("stall_cnt%0d", c), (c == 0) ? DW'(stall_a) : DW'(stall_b), DW'(mstall[c]));
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mn[c]     = 0;
            mstall[c] = 0;
            stuck[c]  = 1'b0;
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < 2; c++) begin
            bit upx;
            bit dnx;
            int maxc;
            upx  = up_valid[c] && exp_up_ready(c);
            dnx  = (mn[c] > 0) && dn_ready[c];
            maxc = (c == 0) ? MAX_A : MAX_B;
            if (clr_cnt[c]) mstall[c] = 0;
            else if (mn[c] > 0 && !dn_ready[c] && mstall[c] < maxc) mstall[c]++;
            stuck[c] = up_valid[c] && !upx;
            if (flush[c]) begin
                mn[c] = 0;
            end else begin
                if (dnx) begin
                    mq[c][0] = mq[c][1];
                    mn[c]--;
                end
                if (upx) begin
                    mq[c][mn[c]] = up_data[c];
                    mn[c]++;
                end
            end
        end
    endtask

    // One cycle: compare outputs against the model, advance across the clock edge, return at the next negedge.
    task automatic cyc();
        #1 check_all();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input int c, input bit uv, input logic [DW-1:0] ud, input bit dr, input bit fl, input bit cl);
        up_valid[c] = uv;
        up_data[c]  = ud;
        dn_ready[c] = dr;
        flush[c]    = fl;
        clr_cnt[c]  = cl;
    endtask

    task automatic rand_drive();
        for (int c = 0; c < 2; c++) begin
            logic [191:0] t;
            if (!stuck[c]) begin
                t           = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                up_valid[c] = ($urandom_range(0, 99) < 60);
                up_data[c]  = t[DW-1:0];
            end
            dn_ready[c] = ($urandom_range(0, 99) < 70);
            flush[c]    = ($urandom_range(0, 39) == 0);
            clr_cnt[c]  = ($urandom_range(0, 59) == 0);
        end
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++) set_in(c, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        check("reset_up_ready", DW'(up_ready[0]), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming: back-to-back 1..4, one per cycle, one-cycle latency.
        for (int k = 1; k <= 4; k++) begin
            set_in(0, 1'b1, DW'(k), 1'b1, 1'b0, 1'b0);
            cyc();
            check("stream_data", dn_data[0], DW'(k));
            check("stream_occ", DW'(occ[0]), DW'(1));
        end
        set_in(0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc();

        // Backpressure: A,B,C with dn_ready low, then release.
        set_in(0, 1'b1, DW'('hA), 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(0, 1'b1, DW'('hB), 1'b0, 1'b0, 1'b0);
        cyc();
        check("bp_occ_two", DW'(occ[0]), DW'(2));
        check("bp_up_ready", DW'(up_ready[0]), DW'(0));
        set_in(0, 1'b1, DW'('hC), 1'b0, 1'b0, 1'b0);
        cyc();
        check("bp_hold_data", dn_data[0], DW'('hA));
        cyc();
        check("bp_stall_cnt", DW'(stall_a), DW'(3));
        set_in(0, 1'b1, DW'('hC), 1'b1, 1'b0, 1'b0);
        cyc();
        check("bp_second", dn_data[0], DW'('hB));
        cyc();
        check("bp_third", dn_data[0], DW'('hC));
        set_in(0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        check("bp_drained", DW'(dn_valid[0]), DW'(0));
        check("bp_stall_kept", DW'(stall_a), DW'(3));

        // Flush in TWO with D offered, then flush in ONE with an accepted D2.
        set_in(0, 1'b1, DW'('hE1), 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(0, 1'b1, DW'('hE2), 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(0, 1'b1, DW'('hD), 1'b0, 1'b1, 1'b0);
        cyc();
        check("flush_valid", DW'(dn_valid[0]), DW'(0));
        check("flush_data", dn_data[0], NOP_A);
        check("flush_occ", DW'(occ[0]), DW'(0));
        set_in(0, 1'b1, DW'('hF), 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(0, 1'b1, DW'('hD2), 1'b0, 1'b1, 1'b0);
        cyc();
        check("flush_drop_valid", DW'(dn_valid[0]), DW'(0));
        set_in(0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc();
        check("flush_no_emerge", DW'(dn_valid[0]), DW'(0));

        // Asynchronous reset while holding two entries.
        set_in(0, 1'b1, DW'('h61), 1'b0, 1'b0, 1'b0);
        cyc();
        set_in(0, 1'b1, DW'('h62), 1'b0, 1'b0, 1'b0);
        cyc();
        check("rst_pre_occ", DW'(occ[0]), DW'(2));
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_valid", DW'(dn_valid[0]), DW'(0));
        check("rst_data", dn_data[0], NOP_A);
        check("rst_occ", DW'(occ[0]), DW'(0));
        check("rst_up_ready", DW'(up_ready[0]), DW'(1));
        set_in(0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single-register stage: combinational ready and bubble-free reload.
        set_in(1, 1'b1, DW'('h51), 1'b1, 1'b0, 1'b1);
        cyc();
        check("s0_first", dn_data[1], DW'('h51));
        set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1 check("s0_ready_low", DW'(up_ready[1]), DW'(0));
        set_in(1, 1'b1, DW'('h52), 1'b1, 1'b0, 1'b0);
        #1 check("s0_ready_high", DW'(up_ready[1]), DW'(1));
        cyc();
        check("s0_reload", dn_data[1], DW'('h52));
        check("s0_reload_valid", DW'(dn_valid[1]), DW'(1));
        set_in(1, 1'b1, DW'('h53), 1'b1, 1'b0, 1'b0);
        cyc();
        check("s0_reload2", dn_data[1], DW'('h53));

        // 4-bit stall counter saturation and clear-wins.
        set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (20) cyc();
        check("cnt_saturate", DW'(stall_b), DW'(15));
        set_in(1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc();
        check("cnt_clear_wins", DW'(stall_b), DW'(0));
        set_in(1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc();

        // Randomized traffic on both stages, with one asynchronous reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) async_reset();
            rand_drive();
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
